mux_rr_scheduler: RTL and testbench
===================================

# mux_rr_scheduler

Round-robin scheduler that shares one 2**N-to-1 selection datapath among 2**N requesters. Each requester offers a W-bit word with a request/acknowledge handshake. The block picks one requester per transfer and drives the select internally. It captures the chosen word into a registered output stage with a valid/ready handshake toward the downstream consumer. It sits between the per-lane producers and the single shared downstream path, and replaces free-running select counters on the multiplexer.

## Interface
- N, default 3: select width; number of requesters = 2**N.
- W, default 8: data word width.
- clock  input  1  system clock; all state changes on rising edge.
- n_reset  input  1  asynchronous active-low reset.
- req  input  2**N  per-requester request; bit i held high while data_in[i] is valid.
- data_in  input  2**N x W  packed per-requester words; lane i at bits [i*W +: W].
- ack  output  2**N  one-hot, combinational; ack[i]=1 means word i is captured at this clock edge.
- out_valid  output  1  output register holds an untaken word.
- out_data  output  W  captured word.
- out_src  output  N  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts out_data when out_valid && out_ready.

## Operation
- States are IDLE (output register empty) and BUSY (out_valid=1). The state is registered.
- Pointer `last` (N bits) holds the index of the most recent grant.
- Winner is the first i with req[i]=1, searching last+1, last+2, … modulo 2**N, ending at `last` itself.
- load = |req && (state==IDLE || out_ready).
- When load=1:
  - ack[winner]=1 and all other ack bits are 0.
  - At the edge: out_data ← data_in[winner], out_src ← winner, last ← winner, state ← BUSY.
- When load=0: ack is all zero.
- BUSY && out_ready && !|req → IDLE at the edge, and out_valid falls.
- BUSY && !out_ready: out_data and out_src are frozen and ack is all zero, regardless of req.
- Requesters hold req and data_in stable until ack. They may drop req without an ack (request withdrawal); the block then ignores that lane.
- A requester that keeps req high after its ack is re-arbitrated at once. It is served again only after every other active requester has had a turn (fairness).
- Pointer wrap: last = 2**N-1 → the search starts at 0.
- out_ready while IDLE has no effect.

## Timing
- Reset (n_reset=0, asynchronous):
  - state=IDLE, out_valid=0, out_data=0, out_src=0, last=2**N-1 (so the first search starts at requester 0).
  - ack=0 is forced combinationally during reset.
- Reset asserted mid-transfer discards the held word; no ack is reissued.
- Latency: req high in cycle t with IDLE → ack in cycle t, out_valid=1 from cycle t+1.
- Throughput: one word per cycle when out_ready stays high and requests are pending. Back-to-back capture occurs with no bubble.
- A transfer with the same-cycle retire and load (BUSY, out_ready=1, |req) replaces out_data at the edge; out_valid stays 1.
- No combinational path from out_ready to out_data or out_valid. A combinational path exists from out_ready and req to ack.

## Structure
- Package mux_sched_pkg:
  - typedef enum logic {IDLE, BUSY} state_t.
  - Function next_index(idx, n) for the modulo-2**N increment.
- Sub-module rr_pick: purely combinational round-robin search. Inputs are req and last; outputs are winner (N bits) and any (1 bit). It is instantiated once.
- Data selection is a W-bit 2**N-to-1 case on winner, inside the top module.
- The top module holds the state register, the pointer, and the output register.

## Test plan
- Reset/idle:
  - Hold n_reset=0 with req=8'hFF → ack=0, out_valid=0, out_src=0.
  - Release reset with out_ready=1 → ack=8'h01, then out_src=0 next cycle.
- Round-robin fairness:
  - Stimulus: req=8'hFF held, out_ready=1, data_in[i]=8'h10+i.
  - Response: out_src sequence 0,1,…,7,0 and out_data 8'h10…8'h17,8'h10, with one word per cycle.
- Skip and wrap:
  - Stimulus: req=8'b1000_0100 with last=2.
  - Response: grants 7, then 2, then 7, with out_data matching each lane.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while BUSY.
  - Response: out_data and out_src are frozen, ack=0 throughout, out_valid=1.
  - On release, the next winner is acked in the same cycle.
- Drain to IDLE:
  - Stimulus: single req[3] pulse until ack, out_ready=1.
  - Response: out_valid high for exactly 1 cycle, then state IDLE; out_valid=0 and ack=0 thereafter.
- Mid-operation reset:
  - Stimulus: assert n_reset while BUSY with out_ready=0.
  - Response: out_valid falls immediately without waiting for clock. After release, the search restarts at requester 0.

Source files
------------

// File: rtl/mux_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin multiplexer scheduler.
package mux_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Increment modulo 2**n; callers cast the result back to their own index width.
    function automatic logic [31:0] next_index(input logic [31:0] idx, input int n);
        logic [31:0] mask;
        mask = (32'd1 << n) - 32'd1;
        return (idx + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational round-robin search: first active request after 'last', ending at 'last'.
module rr_pick
    import mux_sched_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [2**N-1:0] req_i,
    input  logic [N-1:0]    last_i,
    output logic [N-1:0]    winner_o,
    output logic            any_o
);

    localparam int NREQ = 2**N;

    logic [N-1:0] cand;
    logic         found;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        cand     = N'(next_index(32'(last_i), N));
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_i[cand]) begin
                winner_o = cand;
                found    = 1'b1;
            end
            cand = N'(next_index(32'(cand), N));
        end
        any_o = found;
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one 2**N-to-1 word path, with a registered
// valid/ready output stage toward the single downstream consumer.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic                 clock,
    input  logic                 n_reset,
    input  logic [2**N-1:0]      req,
    input  logic [(2**N)*W-1:0]  data_in,
    output logic [2**N-1:0]      ack,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [N-1:0]         out_src,
    input  logic                 out_ready
);

    localparam int NREQ = 2**N;

    state_t         state_q, state_d;
    logic [N-1:0]   last_q,  last_d;
    logic [W-1:0]   data_q,  data_d;
    logic [N-1:0]   src_q,   src_d;

    logic [N-1:0]   winner;
    logic           any_req;
    logic           load;
    logic [W-1:0]   sel_data;

    rr_pick #(.N(N)) u_pick (
        .req_i    (req),
        .last_i   (last_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == N'(i)) begin
                sel_data = data_in[i*W +: W];
            end
        end
    end

    // A capture may overlap a retire: the held word leaves as the new one arrives.
    assign load = any_req && ((state_q == IDLE) || out_ready);

    always_comb begin
        ack = '0;
        if (load && n_reset) begin
            ack[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        data_d  = data_q;
        src_d   = src_q;
        if (load) begin
            state_d = BUSY;
            last_d  = winner;
            data_d  = sel_data;
            src_d   = winner;
        end else if ((state_q == BUSY) && out_ready) begin
            state_d = IDLE;
        end
    end

    // last resets to all-ones so the first search begins at requester 0.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            last_q  <= '1;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign out_valid = (state_q == BUSY);
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler: directed scenarios then random traffic.
module tb_mux_rr_scheduler;

    localparam int N    = 3;
    localparam int W    = 8;
    localparam int NREQ = 8;

    logic            clock;
    logic            n_reset;
    logic [7:0]      req;
    logic [63:0]     data_in;
    logic [7:0]      ack;
    logic            out_valid;
    logic [7:0]      out_data;
    logic [2:0]      out_src;
    logic            out_ready;

    mux_rr_scheduler #(.N(N), .W(W)) dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        int         src;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_last;
    bit   m_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requesting lane after 'last', modulo 8.
    function automatic int ref_winner(input logic [7:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = NREQ - 1;
        m_busy = 1'b0;
        q.delete();
    endtask

    // Drive one cycle of inputs, check ack/out_valid, advance the model.
    task automatic do_cycle(input logic [7:0] r, input logic [63:0] d, input logic rdy,
                            output int lane);
        int         w;
        bit         exp_load;
        logic [7:0] exp_ack;
        exp_t       e;
        req       = r;
        data_in   = d;
        out_ready = rdy;
        @(negedge clock);
        w        = ref_winner(r, m_last);
        exp_load = (w >= 0) && (!m_busy || rdy);
        exp_ack  = '0;
        if (exp_load) exp_ack[w] = 1'b1;
        chk("ack", 64'(ack), 64'(exp_ack));
        chk("out_valid", 64'(out_valid), 64'(m_busy));
        lane = -1;
        if (exp_load) begin
            e.data = d[w*8 +: 8];
            e.src  = w;
            q.push_back(e);
            m_last = w;
            m_busy = 1'b1;
            lane   = w;
        end else if (m_busy && rdy) begin
            m_busy = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor: whatever the DUT presents must be the oldest untaken word.
    always @(negedge clock) begin
        if (n_reset && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_word", 64'(1), 64'(0));
            end else begin
                chk("out_data", 64'(out_data), 64'(q[0].data));
                chk("out_src", 64'(out_src), 64'(q[0].src));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [63:0] din_f;
        logic [63:0] din;
        logic [7:0]  rv;
        logic        rdy;
        bit          pending [NREQ];
        logic [7:0]  pdata   [NREQ];
        int          lane;
        int          exp_lanes [3];

        for (int i = 0; i < NREQ; i++) din_f[i*8 +: 8] = 8'h10 + 8'(i);
        model_reset();

        n_reset   = 1'b0;
        req       = 8'hFF;
        data_in   = din_f;
        out_ready = 1'b0;
        @(negedge clock);
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        @(posedge clock);
        #1;
        n_reset = 1'b1;

        for (int j = 0; j < 9; j++) begin
            do_cycle(8'hFF, din_f, 1'b1, lane);
            chk("rr_lane", 64'(lane), 64'(j % NREQ));
        end
        do_cycle(8'h00, din_f, 1'b1, lane);

        do_cycle(8'h04, din_f, 1'b1, lane);
        chk("set_last2", 64'(lane), 64'(2));
        exp_lanes = '{7, 2, 7};
        for (int j = 0; j < 3; j++) begin
            do_cycle(8'h84, din_f, 1'b1, lane);
            chk("skip_wrap_lane", 64'(lane), 64'(exp_lanes[j]));
        end

        for (int j = 0; j < 5; j++) begin
            do_cycle(8'hFF, din_f, 1'b0, lane);
            chk("bp_no_grant", 64'(lane + 1), 64'(0));
        end
        do_cycle(8'hFF, din_f, 1'b1, lane);
        chk("bp_release_lane", 64'(lane), 64'(0));

        do_cycle(8'h00, din_f, 1'b1, lane);
        do_cycle(8'h08, din_f, 1'b1, lane);
        chk("drain_lane", 64'(lane), 64'(3));
        for (int j = 0; j < 3; j++) do_cycle(8'h00, din_f, 1'b1, lane);

        do_cycle(8'h20, din_f, 1'b0, lane);
        do_cycle(8'h00, din_f, 1'b0, lane);
        #1;
        req     = 8'hFF;
        n_reset = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_ack", 64'(ack), 64'(0));
        model_reset();
        @(negedge clock);
        @(posedge clock);
        #1;
        n_reset = 1'b1;
        do_cycle(8'h42, din_f, 1'b1, lane);
        chk("post_rst_lane", 64'(lane), 64'(1));
        do_cycle(8'h00, din_f, 1'b1, lane);

        for (int i = 0; i < NREQ; i++) begin
            pending[i] = 1'b0;
            pdata[i]   = 8'h00;
        end
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pending[i] && ($urandom % 25 == 0)) begin
                    pending[i] = 1'b0;
                end else if (!pending[i] && ($urandom % 3 == 0)) begin
                    pending[i] = 1'b1;
                    pdata[i]   = 8'($urandom);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                rv[i]          = pending[i];
                din[i*8 +: 8]  = pdata[i];
            end
            rdy = ((c / 50) % 4 == 3) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            do_cycle(rv, din, rdy, lane);
            if (lane >= 0) pending[lane] = 1'b0;
        end

        for (int j = 0; j < 3; j++) do_cycle(8'h00, din_f, 1'b1, lane);
        chk("queue_empty", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
